// File: rtl/rx_check_crc32.sv
// Receive-side Ethernet FCS checker.
// Absorbs every frame byte (FCS included) into a CRC-32, compares against the
// good-frame residue, forwards payload through a 4-byte delay line so the FCS
// is never emitted, and reports status with a one-cycle end-of-frame strobe.
module rx_check_crc32 #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  i_data,
  input  logic        i_vl,
  input  logic        i_frame,
  output logic [7:0]  o_data,
  output logic        o_vl,
  output logic        o_eof,
  output logic        o_crc_ok,
  output logic        o_crc_err,
  output logic        o_runt,
  output logic        o_long,
  output logic [15:0] o_len
);

  typedef enum logic {IDLE, RECV} state_t;

  localparam logic [31:0] POLY    = 32'h04C11DB7;
  localparam logic [31:0] RESIDUE = 32'hC704DD7B;
  localparam logic [15:0] MIN_L   = 16'(MIN_LEN);
  localparam logic [15:0] MAX_L   = 16'(MAX_LEN);

  state_t          state, state_next;
  logic            absorb;
  logic            finish;
  logic            seen_low;
  logic [31:0]     crc;
  logic [15:0]     count;
  logic [2:0]      fill;
  logic [3:0][7:0] dly;
  logic            crc_good;

  // One byte of CRC-32, wire bit 0 first, register kept non-reflected.
  function automatic logic [31:0] crc_step(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    c = c_in;
    for (int unsigned i = 0; i < 8; i++) begin
      if (c[31] ^ d[i]) c = {c[30:0], 1'b0} ^ POLY;
      else              c = {c[30:0], 1'b0};
    end
    return c;
  endfunction

  assign crc_good = (crc == RESIDUE) && (count >= 16'd4);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next state plus byte-absorb / end-of-frame decisions.
  // A frame may only start once i_frame has been seen low since reset, so the
  // tail of a frame interrupted by reset is never checked.
  always_comb begin
    state_next = state;
    absorb     = 1'b0;
    finish     = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_frame && seen_low) begin
          state_next = RECV;
          absorb     = i_vl;
        end
      end
      RECV: begin
        if (i_frame) begin
          absorb = i_vl;
        end else begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
    endcase
  end

  // CRC, counters, delay line and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_low  <= 1'b0;
      crc       <= '1;
      count     <= '0;
      fill      <= '0;
      dly       <= '0;
      o_data    <= '0;
      o_vl      <= 1'b0;
      o_eof     <= 1'b0;
      o_crc_ok  <= 1'b0;
      o_crc_err <= 1'b0;
      o_runt    <= 1'b0;
      o_long    <= 1'b0;
      o_len     <= '0;
    end else begin
      o_vl      <= 1'b0;
      o_eof     <= 1'b0;
      o_crc_ok  <= 1'b0;
      o_crc_err <= 1'b0;
      o_runt    <= 1'b0;
      o_long    <= 1'b0;
      if (!i_frame) seen_low <= 1'b1;
      if (absorb) begin
        crc <= crc_step(crc, i_data);
        if (count != '1) count <= count + 16'd1;
        dly <= {dly[2:0], i_data};
        if (fill == 3'd4) begin
          o_data <= dly[3];
          o_vl   <= 1'b1;
        end else begin
          fill <= fill + 3'd1;
        end
      end
      // The 4 bytes still in the delay line are the FCS; drop them.
      if (finish) begin
        o_eof     <= 1'b1;
        o_crc_ok  <= crc_good;
        o_crc_err <= !crc_good;
        o_runt    <= (count < MIN_L);
        o_long    <= (count > MAX_L);
        o_len     <= (count >= 16'd4) ? count - 16'd4 : '0;
        crc       <= '1;
        count     <= '0;
        fill      <= '0;
        dly       <= '0;
      end
    end
  end

endmodule
